// File: rtl/posit_divsqrt_arbiter.sv
// Round-robin arbiter that shares one posit DIV/SQRT opgroup among NumReq requesters.
// Optional perf counters (perf_ops_o, perf_busy_cycles_o) when POSIT_DIVSQRT_ARB_PERF_EN is defined.
module posit_divsqrt_arbiter #(
  parameter int NumReq   = 2,
  parameter int WIDTH    = 32,
  parameter int TagWidth = 4,
  localparam int IdxW    = $clog2(NumReq),
  localparam int UTagW   = TagWidth + IdxW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*2*WIDTH-1:0]    req_operands_i,
  input  logic [NumReq-1:0]            req_sqrt_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [WIDTH-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  output logic [2*WIDTH-1:0]           unit_operands_o,
  output logic                         unit_op_sqrt_o,
  output logic [UTagW-1:0]             unit_tag_o,
  output logic                         unit_in_valid_o,
  input  logic                         unit_in_ready_i,
  input  logic [WIDTH-1:0]             unit_result_i,
  input  logic [4:0]                   unit_status_i,
  input  logic [UTagW-1:0]             unit_tag_i,
  input  logic                         unit_out_valid_i,
  output logic                         unit_out_ready_o,
  input  logic                         flush_i,
  output logic                         unit_flush_o,
  output logic                         tag_err_o,
`ifdef POSIT_DIVSQRT_ARB_PERF_EN
  output logic [31:0]                  perf_ops_o,
  output logic [31:0]                  perf_busy_cycles_o,
`endif
  output logic                         busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr;
  logic                tag_err;

  logic [2*WIDTH-1:0]  opnd_p0;
  logic                sqrt_p0;
  logic [TagWidth-1:0] tag_p0;
  logic [IdxW-1:0]     gidx_p0;

  logic [WIDTH-1:0]    res_p1;
  logic [4:0]          stat_p1;
  logic [TagWidth-1:0] rtag_p1;

  logic                halt;
  logic                accept;
  logic                capture;
  logic                rsp_done;
  logic [IdxW:0]       pick;
  logic                pick_vld;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     ret_idx;

  // First valid requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [IdxW:0] rr_pick(input logic [NumReq-1:0] vld,
                                            input logic [IdxW-1:0]   ptr);
    logic [IdxW:0] r;
    int            c;
    r = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NumReq;
      if (vld[c]) r = {1'b1, IdxW'(c)};
    end
    return r;
  endfunction

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    if (int'(p) >= NumReq - 1) return '0;
    return p + 1'b1;
  endfunction

  assign halt     = flush_i | rst_i;
  assign pick     = rr_pick(req_valid_i, rr_ptr);
  assign pick_vld = pick[IdxW];
  assign pick_idx = pick[IdxW-1:0];
  assign ret_idx  = unit_tag_i[UTagW-1 -: IdxW];

  always_comb begin
    state_d          = state_q;
    req_ready_o      = '0;
    rsp_valid_o      = '0;
    unit_in_valid_o  = 1'b0;
    unit_out_ready_o = 1'b0;
    accept           = 1'b0;
    capture          = 1'b0;
    rsp_done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !halt) begin
          accept                = 1'b1;
          req_ready_o[pick_idx] = 1'b1;
          state_d               = S_ISSUE;
        end
      end
      S_ISSUE: begin
        unit_in_valid_o = ~halt;
        if (unit_in_ready_i && !halt) state_d = S_WAIT;
      end
      S_WAIT: begin
        unit_out_ready_o = 1'b1;
        if (unit_out_valid_i && !halt) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o[gidx_p0] = ~halt;
        if (rsp_ready_i[gidx_p0] && !halt) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush abandons whatever is in flight, with no response.
    if (halt) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_ptr  <= '0;
      tag_err <= 1'b0;
      res_p1  <= '0;
      stat_p1 <= '0;
      rtag_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rr_ptr <= ptr_inc(pick_idx);
      if (capture) begin
        res_p1  <= unit_result_i;
        stat_p1 <= unit_status_i;
        rtag_p1 <= unit_tag_i[TagWidth-1:0];
        if (ret_idx != gidx_p0) tag_err <= 1'b1;
      end
    end
  end

  // Stage p0: payload captured from the granted requester
  always_ff @(posedge clk_i) begin
    if (accept) begin
      opnd_p0 <= req_operands_i[int'(pick_idx)*2*WIDTH +: 2*WIDTH];
      sqrt_p0 <= req_sqrt_i[pick_idx];
      tag_p0  <= req_tag_i[int'(pick_idx)*TagWidth +: TagWidth];
      gidx_p0 <= pick_idx;
    end
  end

  assign unit_operands_o = opnd_p0;
  assign unit_op_sqrt_o  = sqrt_p0;
  assign unit_tag_o      = {gidx_p0, tag_p0};
  assign unit_flush_o    = halt;

  // Stage p1: registered response on the shared buses
  assign rsp_result_o = res_p1;
  assign rsp_status_o = stat_p1;
  assign rsp_tag_o    = rtag_p1;
  assign tag_err_o    = tag_err;
  assign busy_o       = (state_q != S_IDLE);

`ifdef POSIT_DIVSQRT_ARB_PERF_EN
  logic [31:0] ops_cnt;
  logic [31:0] busy_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ops_cnt  <= '0;
      busy_cnt <= '0;
    end else begin
      if (rsp_done) ops_cnt  <= sat_inc(ops_cnt);
      if (busy_o)   busy_cnt <= sat_inc(busy_cnt);
    end
  end

  assign perf_ops_o         = ops_cnt;
  assign perf_busy_cycles_o = busy_cnt;
`endif

endmodule

// File: tb/tb_posit_divsqrt_arbiter.sv
// Bench for posit_divsqrt_arbiter: plays both requesters and the DIV/SQRT opgroup unit,
// checking grants, pass-through payloads and routed responses against a reference model.
module tb_posit_divsqrt_arbiter;
  localparam int N   = 2;
  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int UTW = TW + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_sqrt, rsp_valid, rsp_ready;
  logic [N*2*W-1:0] req_operands;
  logic [N*TW-1:0]  req_tag;
  logic [W-1:0]     rsp_result, unit_result;
  logic [4:0]       rsp_status, unit_status;
  logic [TW-1:0]    rsp_tag;
  logic [2*W-1:0]   unit_operands;
  logic             unit_op_sqrt, unit_in_valid, unit_in_ready, unit_out_valid, unit_out_ready;
  logic [UTW-1:0]   unit_tag_out, unit_tag_in;
  logic             flush, unit_flush, tag_err, busy;
`ifdef POSIT_DIVSQRT_ARB_PERF_EN
  logic [31:0]      perf_ops, perf_busy;
`endif

  always #5 clk = ~clk;

  posit_divsqrt_arbiter #(.NumReq(N), .WIDTH(W), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_sqrt_i(req_sqrt), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
    .unit_operands_o(unit_operands), .unit_op_sqrt_o(unit_op_sqrt), .unit_tag_o(unit_tag_out),
    .unit_in_valid_o(unit_in_valid), .unit_in_ready_i(unit_in_ready),
    .unit_result_i(unit_result), .unit_status_i(unit_status), .unit_tag_i(unit_tag_in),
    .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
    .flush_i(flush), .unit_flush_o(unit_flush), .tag_err_o(tag_err),
`ifdef POSIT_DIVSQRT_ARB_PERF_EN
    .perf_ops_o(perf_ops), .perf_busy_cycles_o(perf_busy),
`endif
    .busy_o(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural stand-in for the opgroup: {status, result}. Known posit32 cases are exact.
  function automatic logic [36:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic sq);
    if (sq) begin
      if (a == 32'h5000_0000) return {5'b00000, 32'h4800_0000};
      return {5'b00001, a ^ 32'h5A5A_0000};
    end
    if (b == 32'h0) return {5'b01000, 32'h8000_0000};
    if (a == 32'h5000_0000 && b == 32'h4800_0000) return {5'b00000, 32'h4800_0000};
    return {a[4:0] ^ b[4:0], a + {b[15:0], b[31:16]}};
  endfunction

  // Requester-side reference state
  logic          pv[N];
  logic [31:0]   pa[N], pb[N];
  logic          psq[N];
  logic [TW-1:0] ptg[N];
  int            m_rr;
  int            n_done;

  logic [31:0]   ex_a, ex_b;
  logic          ex_sq;
  logic [TW-1:0] ex_tag;
  int            ex_g;

  // Unit model state
  logic          u_pend;
  logic [36:0]   u_res;
  logic [UTW-1:0] u_tag;
  int            u_cnt;
  int            u_lat_fix = 0;
  logic          u_corrupt = 1'b0;
  int            u_in_hs   = 0;

  initial begin
    unit_in_ready  = 1'b0;
    unit_out_valid = 1'b0;
    unit_result    = '0;
    unit_status    = '0;
    unit_tag_in    = '0;
    u_pend         = 1'b0;
    u_res          = '0;
    u_tag          = '0;
    u_cnt          = 0;
    forever begin
      @(negedge clk);
      unit_in_ready = ($urandom_range(0, 2) != 0);
      if (u_pend && u_cnt > 0) u_cnt--;
      unit_out_valid = u_pend && (u_cnt == 0);
      unit_result    = u_res[31:0];
      unit_status    = u_res[36:32];
      unit_tag_in    = u_tag;
      #3;
      if (unit_flush) begin
        u_pend = 1'b0;
      end else begin
        if (unit_out_valid && unit_out_ready) u_pend = 1'b0;
        if (unit_in_valid && unit_in_ready) begin
          u_in_hs++;
          check("unit_ops", unit_operands, {ex_b, ex_a});
          check("unit_sqrt", unit_op_sqrt, ex_sq);
          check("unit_tag", unit_tag_out, {ex_g[0], ex_tag});
          u_res  = unit_fn(unit_operands[31:0], unit_operands[63:32], unit_op_sqrt);
          u_tag  = u_corrupt ? (unit_tag_out ^ {1'b1, {TW{1'b0}}}) : unit_tag_out;
          u_cnt  = (u_lat_fix > 0) ? u_lat_fix : int'($urandom_range(1, 4));
          u_pend = 1'b1;
        end
      end
    end
  end

  task automatic drive_reqs();
    for (int r = 0; r < N; r++) begin
      req_valid[r]               = pv[r];
      req_sqrt[r]                = psq[r];
      req_tag[r*TW +: TW]        = ptg[r];
      req_operands[r*2*W +: 2*W] = {pb[r], pa[r]};
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic sq, input logic [TW-1:0] tg);
    pv[r] = 1'b1; pa[r] = a; pb[r] = b; psq[r] = sq; ptg[r] = tg;
    drive_reqs();
  endtask

  function automatic int model_grant();
    for (int i = 0; i < N; i++)
      if (pv[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; flush = 1'b0; rsp_ready = '0;
    for (int r = 0; r < N; r++) pv[r] = 1'b0;
    drive_reqs();
    @(negedge clk); #2;
    check("rst_flush_fwd", unit_flush, 1'b1);
    check("rst_req_ready", req_ready, '0);
    @(negedge clk); #1;
    rst = 1'b0; m_rr = 0; n_done = 0;
    #1;
  endtask

  // Waits for the model's expected grant; leaves the accepted requester deasserted.
  task automatic accept_one(input bit drop, output int g);
    int cyc;
    g = model_grant();
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge clk); #2; cyc++;
    end
    check("grant", req_ready, (g < 0) ? 64'd0 : 64'(1 << g));
    if (g < 0 || req_ready == '0) begin
      g = -1;
      return;
    end
    ex_a = pa[g]; ex_b = pb[g]; ex_sq = psq[g]; ex_tag = ptg[g]; ex_g = g;
    m_rr  = (g + 1) % N;
    pv[g] = 1'b0;
    @(negedge clk); #1;
    if (drop)
      for (int r = 0; r < N; r++) if (pv[r] && $urandom_range(0, 1) == 1) pv[r] = 1'b0;
    drive_reqs();
    #1;
  endtask

  task automatic finish_one(input int hold, input int g);
    int cyc;
    logic [36:0] er;
    er  = unit_fn(ex_a, ex_b, ex_sq);
    cyc = 0;
    while (rsp_valid == '0 && cyc < 100) begin
      @(negedge clk); #2; cyc++;
    end
    check("rsp_valid", rsp_valid, 64'(1 << g));
    check("rsp_result", rsp_result, er[31:0]);
    check("rsp_status", rsp_status, er[36:32]);
    check("rsp_tag", rsp_tag, ex_tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #2;
      check("hold_valid", rsp_valid, 64'(1 << g));
      check("hold_result", rsp_result, er[31:0]);
      check("hold_req_ready", req_ready, '0);
      check("hold_busy", busy, 1'b1);
    end
    @(negedge clk); #1;
    rsp_ready = N'(1 << g);
    @(negedge clk); #1;
    rsp_ready = '0;
    n_done++;
    #1;
    check("idle_after_rsp", busy, 1'b0);
  endtask

  task automatic serve(input int hold, input bit drop, output int g);
    accept_one(drop, g);
    if (g >= 0) finish_one(hold, g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, h0, cyc;
    rst = 1'b1; flush = 1'b0; rsp_ready = '0; req_valid = '0; req_sqrt = '0;
    req_tag = '0; req_operands = '0;
    for (int r = 0; r < N; r++) begin
      pv[r] = 1'b0; pa[r] = '0; pb[r] = '0; psq[r] = 1'b0; ptg[r] = '0;
    end
    ex_a = '0; ex_b = '0; ex_sq = 1'b0; ex_tag = '0; ex_g = 0;
    m_rr = 0; n_done = 0;
    do_reset();

    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_result", rsp_result, '0);
    check("reset_status", rsp_status, '0);
    check("reset_tag", rsp_tag, '0);
    check("reset_in_valid", unit_in_valid, 1'b0);
    check("reset_tag_err", tag_err, 1'b0);

    // 4.0 / 2.0 with 10 cycles of response backpressure
    set_req(0, 32'h5000_0000, 32'h4800_0000, 1'b0, 4'd3);
    serve(10, 1'b0, g);
    check("div_grant", g, 0);
    check("div_result", rsp_result, 32'h4800_0000);
    check("div_status", rsp_status, 5'b00000);
    check("div_tag", rsp_tag, 4'd3);

    set_req(1, 32'h5000_0000, 32'h0, 1'b1, 4'd5);
    serve(0, 1'b0, g);
    check("sqrt_grant", g, 1);
    check("sqrt_result", rsp_result, 32'h4800_0000);

    set_req(0, 32'h4000_0000, 32'h0, 1'b0, 4'd7);
    serve(1, 1'b0, g);
    check("dz_result", rsp_result, 32'h8000_0000);
    check("dz_flag", rsp_status[3], 1'b1);

    // Both requesters continuously valid: grants alternate from 0
    do_reset();
    set_req(0, $urandom, $urandom, 1'b0, 4'($urandom));
    set_req(1, $urandom, $urandom, 1'b1, 4'($urandom));
    for (int i = 0; i < 6; i++) begin
      serve(0, 1'b0, g);
      check("fair_order", g, i % 2);
      set_req(g, $urandom, $urandom, 1'($urandom), 4'($urandom));
    end
    while (model_grant() >= 0) serve(0, 1'b0, g);

    // Flush competing with a request in IDLE
    set_req(0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 4'd9);
    flush = 1'b1;
    #1;
    check("flush_idle_ready", req_ready, '0);
    check("flush_idle_fwd", unit_flush, 1'b1);
    @(negedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_idle_busy", busy, 1'b0);
    serve(0, 1'b0, g);
    check("after_flush_grant", g, 0);

    // Flush while the unit is working
    u_lat_fix = 8;
    h0 = u_in_hs;
    set_req(1, 32'h2222_0000, 32'h1111_0000, 1'b0, 4'd2);
    accept_one(1'b0, g);
    cyc = 0;
    while (u_in_hs == h0 && cyc < 50) begin
      @(negedge clk); #2; cyc++;
    end
    check("fw_in_wait", unit_out_ready, 1'b1);
    flush = 1'b1;
    #1;
    check("fw_flush_fwd", unit_flush, 1'b1);
    @(negedge clk); #1;
    flush = 1'b0;
    #1;
    check("fw_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check("fw_no_rsp", rsp_valid, '0);
    end
    u_lat_fix = 0;
    set_req(1, 32'h5000_0000, 32'h4800_0000, 1'b0, 4'd11);
    serve(0, 1'b0, g);
    check("fw_next_result", rsp_result, 32'h4800_0000);

    // Unit returns a foreign grant index: sticky error, still routed by capture
    u_corrupt = 1'b1;
    set_req(0, 32'h0F0F_0F0F, 32'h3333_3333, 1'b0, 4'd6);
    serve(0, 1'b0, g);
    u_corrupt = 1'b0;
    check("tag_err_set", tag_err, 1'b1);
    set_req(1, 32'h0A0A_0A0A, 32'h1313_1313, 1'b0, 4'd1);
    serve(0, 1'b0, g);
    check("tag_err_sticky", tag_err, 1'b1);

    // Randomized traffic with drops before acceptance
    do_reset();
    check("tag_err_cleared", tag_err, 1'b0);
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < N; r++)
        if (!pv[r] && $urandom_range(0, 1) == 1)
          set_req(r, $urandom, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
                  1'($urandom), 4'($urandom));
      if (model_grant() < 0)
        set_req(int'($urandom_range(0, N - 1)), $urandom, $urandom, 1'($urandom), 4'($urandom));
      serve(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), g);
    end
    while (model_grant() >= 0) serve(0, 1'b0, g);
`ifdef POSIT_DIVSQRT_ARB_PERF_EN
    check("perf_ops", perf_ops, 32'(n_done));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/posit_divsqrt_arbiter.md
Name: posit_divsqrt_arbiter

Overview:
Shares one multi-cycle posit DIVSQRT opgroup block among NumReq independent requesters (e.g. two issue ports or two cores). It runs round-robin arbitration, sequences one operation at a time through the unit, and routes the result, status and tag back to the winning requester. It sits between the issue logic and the posit_opgroup_block instance configured with OpGroup = DIVSQRT.

Parameters:
NumReq, 2, number of requesters (2..8)
WIDTH, 32, posit operand/result width (POSIT32)
TagWidth, 4, requester-supplied tag width, returned unchanged with the result

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: one clock; reset is synchronous and active-high
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester request accepted (one-hot or zero)
req_operands_i  in  NumReq*2*WIDTH  {op_b, op_a} per requester; DIV computes a/b, SQRT uses a
req_sqrt_i  in  NumReq  1 = SQRT, 0 = DIV
req_tag_i  in  NumReq*TagWidth  per-requester tag
rsp_valid_o  out  NumReq  per-requester response valid (one-hot or zero)
rsp_ready_i  in  NumReq  per-requester response ready
rsp_result_o  out  WIDTH  result, shared bus; valid for the requester flagged in rsp_valid_o
rsp_status_o  out  5  posit status {NV,DZ,OF,UF,NX}, shared
rsp_tag_o  out  TagWidth  echoed tag, shared
unit_operands_o  out  2*WIDTH  to opgroup operands_i
unit_op_sqrt_o  out  1  to opgroup op_i (DIV/SQRT)
unit_tag_o  out  TagWidth+$clog2(NumReq)  {grant index, tag} to opgroup tag_i
unit_in_valid_o  out  1  to opgroup in_valid_i
unit_in_ready_i  in  1  from opgroup in_ready_o
unit_result_i  in  WIDTH  from opgroup result_o
unit_status_i  in  5  from opgroup status_o
unit_tag_i  in  TagWidth+$clog2(NumReq)  from opgroup tag_o
unit_out_valid_i  in  1  from opgroup out_valid_o
unit_out_ready_o  out  1  to opgroup out_ready_i
flush_i  in  1  abort the current operation; forwarded to unit_flush_o
unit_flush_o  out  1  to opgroup flush_i
busy_o  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE, rr_ptr=0, all valids/readies 0, registered result/status/tag cleared to 0.
- IDLE: grant = first requester with req_valid_i set, searching from rr_ptr upward with wrap-around. Assert req_ready_o[grant] combinationally in the same cycle. Capture operands, sqrt bit, tag and grant index. rr_ptr <= grant+1 mod NumReq. Next state ISSUE. With no valid requester, stay in IDLE.
- ISSUE: unit_in_valid_o=1 with the captured payload, held stable until unit_in_ready_i. On the handshake, go to WAIT.
- WAIT: unit_out_ready_o=1. On unit_out_valid_i, register result, status and tag, then go to RESP. If the returned grant index differs from the captured one, latch a sticky tag_err and still route by the captured index.
- RESP: rsp_valid_o[grant]=1 and the shared buses hold the registered values. On rsp_ready_i[grant], go to IDLE. Other requesters see rsp_valid_o=0.
- Minimum accept-to-response latency: 1 (ISSUE) + unit latency + 1 (RESP register).
- Throughput: one operation outstanding at a time. The next grant is evaluated in the IDLE cycle after the response handshake, so there is no back-to-back bypass.
- A requester dropping req_valid_i before acceptance is legal; a dropped request is never granted.
- flush_i (any state): unit_flush_o=flush_i in the same cycle, FSM -> IDLE next cycle, no response is issued. If flush_i and a req handshake occur in the same IDLE cycle, flush wins and req_ready_o stays 0.
- rst_i mid-operation behaves as a flush plus a clear of rr_ptr and tag_err. unit_flush_o is also asserted while rst_i is high.
- Payload widths pass through unmodified. No arithmetic is done on operands.

Optional Feature:
Macro: POSIT_DIVSQRT_ARB_PERF_EN.
- Defined: adds outputs perf_ops_o[31:0] and perf_busy_cycles_o[31:0], both clearing on rst_i. perf_ops_o counts completed RESP handshakes. perf_busy_cycles_o counts cycles with busy_o=1. Both counters saturate at 32'hFFFFFFFF, do not wrap, and are not cleared by flush_i.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Single DIV: req0 a=32'h50000000 (4.0), b=32'h48000000 (2.0), tag=3 -> rsp_valid_o=2'b01, rsp_result_o=32'h48000000, status=0, rsp_tag_o=3.
- Single SQRT: req1 a=32'h50000000, sqrt=1 -> rsp_valid_o=2'b10, result=32'h48000000.
- Fairness: req0 and req1 held valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1, starting with 0 after reset.
- Divide by zero: a=32'h40000000, b=32'h00000000 -> result=32'h80000000 (NaR), status DZ bit set.
- Backpressure: hold rsp_ready_i=0 for 10 cycles in RESP -> rsp_* values stable, req_ready_o=0 throughout, busy_o=1.
- Flush in WAIT: flush_i pulsed for 1 cycle -> unit_flush_o=1 that cycle, IDLE next cycle, no rsp_valid_o; the next request completes normally.
